// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial X = A - B, one full-subtractor step per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   X,
    output logic                  busy
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic                  ovf
`endif
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] a_sr, b_sr, diff;
    logic [DATA_WIDTH:0]   diff_n;
    logic [CW-1:0]         cnt;
    logic                  br, br_n, d, last, accept;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic                  sa, sb;
`endif

    assign accept = in_valid && in_ready;
    assign last   = cnt == CW'(DATA_WIDTH - 1);
    assign d      = a_sr[0] ^ b_sr[0] ^ br;
    assign br_n   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign diff_n = {d, diff};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? SHIFT : IDLE;
            SHIFT:   state_n = last ? DONE : SHIFT;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered alongside the state so no input reaches them combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= state_n == IDLE;
            busy      <= state_n == SHIFT;
            out_valid <= state_n == DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            diff <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            X    <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            sa   <= 1'b0;
            sb   <= 1'b0;
            ovf  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr <= A;
            b_sr <= B;
            diff <= '0;
            br   <= 1'b0;
            cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            sa   <= A[DATA_WIDTH-1];
            sb   <= B[DATA_WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            diff <= diff_n[DATA_WIDTH:1];
            br   <= br_n;
            cnt  <= cnt + 1'b1;
            // X is loaded only on the final step so it stays put between operations.
            if (last) begin
                X <= {br_n, diff_n[DATA_WIDTH:1]};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                ovf <= (sa != sb) && (d != sa);
`endif
            end
        end
    end
endmodule
